adc_serial_responder: RTL

// Slave/responder end of the 13-bit serial ADC link: emulates the ADC on the bench and in loopback builds.

---
 rtl/adc_serial_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/adc_serial_responder.sv
// Serial ADC responder: shifts one zero-padded sample per ADC_CS window onto DATA_OUT, MSB first.
// Pin edges act SYNC_STAGES+1 CLK later; a one-deep holding register (valid/ready) feeds the frames.
module adc_serial_responder #(
   parameter int FRAME_BITS  = 13,
   parameter int DATA_BITS   = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ADC_CLK,
   input  logic                 ADC_CS,
   output logic                 DATA_OUT,
   input  logic [DATA_BITS-1:0] SAMPLE_IN,
   input  logic                 SAMPLE_VALID,
   output logic                 SAMPLE_READY,
   output logic                 BUSY,
   output logic                 FRAME_DONE,
   output logic                 FRAME_ERR,
   output logic                 UNDERRUN
);

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] cs_sync, sck_sync;
   logic                   cs_prev, sck_prev;
   logic                   cs_s, sck_s;
   logic                   cs_fall, cs_rise, sck_rise, sck_fall;

   logic [FRAME_BITS-1:0]  shreg;
   logic [CW-1:0]          bitcnt;
   logic                   hold_full;
   logic [DATA_BITS-1:0]   hold_dat;
   logic [DATA_BITS-1:0]   last_sample;
   logic [DATA_BITS-1:0]   sel;
   logic [FRAME_BITS-1:0]  frame_word;

   logic load_frame, cnt_en, shift_en, clr_sh;
   logic done_set, err_set, und_set;

   // Synchronisers idle at the link's quiescent levels: CS deasserted, clock low.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cs_sync  <= '1;
         sck_sync <= '0;
         cs_prev  <= 1'b1;
         sck_prev <= 1'b0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], ADC_CS};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], ADC_CLK};
         cs_prev  <= cs_s;
         sck_prev <= sck_s;
      end
   end

   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_fall  = cs_prev & ~cs_s;
   assign cs_rise  = ~cs_prev & cs_s;
   assign sck_rise = ~sck_prev & sck_s;
   assign sck_fall = sck_prev & ~sck_s;

   // Source priority: loaded sample, then same-cycle bypass, then repeat of the previous frame.
   always_comb begin
      sel = last_sample;
      if (hold_full)
         sel = hold_dat;
      else if (SAMPLE_VALID)
         sel = SAMPLE_IN;
   end

   assign frame_word = FRAME_BITS'(sel);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      cnt_en     = 1'b0;
      shift_en   = 1'b0;
      clr_sh     = 1'b0;
      done_set   = 1'b0;
      err_set    = 1'b0;
      und_set    = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               load_frame = 1'b1;
               und_set    = ~hold_full & ~SAMPLE_VALID;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            // The rising edge is counted before a coincident CS release is judged.
            if (sck_rise) begin
               cnt_en = 1'b1;
               if (bitcnt == LAST_BIT) begin
                  done_set  = 1'b1;
                  clr_sh    = 1'b1;
                  state_nxt = DONE;
               end
            end
            if (cs_rise) begin
               clr_sh    = 1'b1;
               err_set   = ~done_set;
               state_nxt = IDLE;
            end else if (sck_fall) begin
               shift_en = 1'b1;
            end
         end
         DONE: begin
            if (cs_rise)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shreg       <= '0;
         bitcnt      <= '0;
         last_sample <= '0;
         FRAME_DONE  <= 1'b0;
         FRAME_ERR   <= 1'b0;
         UNDERRUN    <= 1'b0;
      end else begin
         if (load_frame) begin
            shreg       <= frame_word;
            bitcnt      <= '0;
            last_sample <= sel;
         end else if (clr_sh) begin
            shreg <= '0;
         end else if (shift_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
         end
         if (cnt_en)
            bitcnt <= bitcnt + 1'b1;
         FRAME_DONE <= done_set;
         FRAME_ERR  <= err_set;
         UNDERRUN   <= und_set;
      end
   end

   // A bypassed sample goes straight into the frame, so it must not also fill the register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_full <= 1'b0;
         hold_dat  <= '0;
      end else if (load_frame) begin
         hold_full <= 1'b0;
      end else if (SAMPLE_VALID && !hold_full) begin
         hold_full <= 1'b1;
         hold_dat  <= SAMPLE_IN;
      end
   end

   assign DATA_OUT     = shreg[FRAME_BITS-1];
   assign SAMPLE_READY = ~hold_full;
   assign BUSY         = (state != IDLE);

endmodule
